// File: rtl/line_burst_adapter.sv
// Bridges single-cycle cache line requests to a multi-beat burst memory port,
// serialising write lines and reassembling read beats into one line.
module line_burst_adapter #(
    parameter int BURST_W = 64,
    parameter int BURSTS  = 4,
    localparam int LINE_W = BURST_W * BURSTS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LINE_W-1:0] line_i,
    output logic [LINE_W-1:0] line_o,
    input  logic [31:0]       address_i,
    input  logic              read_i,
    input  logic              write_i,
    output logic              resp_o,
    input  logic [BURST_W-1:0] burst_i,
    output logic [BURST_W-1:0] burst_o,
    output logic [31:0]       address_o,
    output logic              read_o,
    output logic              write_o,
    input  logic              resp_i
);

    localparam int CNT_W = $clog2(BURSTS) + 1;
    localparam int IDX_W = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam int OFF_W = $clog2(LINE_W / 8);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [LINE_W-1:0]   line_buf_reg, line_buf_next;
    logic [31:0]         addr_reg, addr_next;
    logic [BURST_W-1:0]  beat_w [BURSTS];
    logic [IDX_W-1:0]    cnt_idx;
    logic                last_beat;
    logic                load_line;
    logic                unused_addr_bits;

    // Byte offset within the line never reaches memory; addresses are line-aligned.
    assign unused_addr_bits = ^address_i[OFF_W-1:0];

    assign cnt_idx   = cnt_reg[IDX_W-1:0];
    assign last_beat = resp_i && (cnt_reg == CNT_W'(BURSTS - 1));
    assign load_line = (state_reg == IDLE) && !read_i && write_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Read wins when both requests arrive together.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (read_i) begin
                    state_next = READ;
                end else if (write_i) begin
                    state_next = WRITE;
                end
            end
            READ, WRITE: begin
                if (last_beat) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        read_o  = 1'b0;
        write_o = 1'b0;
        resp_o  = 1'b0;
        burst_o = '0;
        case (state_reg)
            READ:  read_o = 1'b1;
            WRITE: begin
                write_o = 1'b1;
                burst_o = beat_w[cnt_idx];
            end
            DONE:  resp_o = 1'b1;
            default: ;
        endcase
    end

    assign line_o    = line_buf_reg;
    assign address_o = addr_reg;

    // Address is cleared on the way back to IDLE so it reads as zero between requests.
    always_comb begin
        cnt_next  = cnt_reg;
        addr_next = addr_reg;
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (read_i || write_i) begin
                    addr_next = {address_i[31:OFF_W], {OFF_W{1'b0}}};
                end
            end
            READ, WRITE: begin
                if (resp_i) begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            DONE:    addr_next = '0;
            default: ;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < BURSTS; gi++) begin : g_beat
            logic beat_we;
            assign beat_we    = (state_reg == READ) && resp_i && (cnt_idx == IDX_W'(gi));
            assign beat_w[gi] = line_buf_reg[gi*BURST_W +: BURST_W];
            assign line_buf_next[gi*BURST_W +: BURST_W] =
                load_line ? line_i[gi*BURST_W +: BURST_W] :
                beat_we   ? burst_i                       :
                            beat_w[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg      <= '0;
            addr_reg     <= '0;
            line_buf_reg <= '0;
        end else begin
            cnt_reg      <= cnt_next;
            addr_reg     <= addr_next;
            line_buf_reg <= line_buf_next;
        end
    end

endmodule

// File: tb/tb_line_burst_adapter.sv
// Self-checking bench for line_burst_adapter: a behavioural burst memory and
// line model drive directed and randomized line transactions.
module tb_line_burst_adapter;

    logic         clk = 1'b0;
    logic         rst;
    logic [255:0] line_i, line_o;
    logic [31:0]  address_i, address_o;
    logic         read_i, write_i, resp_o;
    logic [63:0]  burst_i, burst_o;
    logic         read_o, write_o, resp_i;

    int n_cmp = 0;
    int n_bad = 0;

    line_burst_adapter #(.BURST_W(64), .BURSTS(4)) dut (
        .clk(clk), .rst(rst),
        .line_i(line_i), .line_o(line_o),
        .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
        .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
        .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    // One cache transaction against a memory model; called at a negedge, returns at
    // the negedge of the cycle after resp_o (adapter idle again).
    task automatic run_txn(input string tag, input bit is_wr, input bit both,
                           input logic [31:0] addr, input logic [255:0] wline,
                           input logic [3:0][63:0] rd_beats, input int delay,
                           input logic [15:0] gap);
        logic [255:0] exp_line;
        logic [31:0]  exp_addr;
        bit           exp_wr, last_sent, saw_resp;
        int           k, since;
        exp_line = '0;
        for (int i = 0; i < 4; i++) exp_line = exp_line | (256'(rd_beats[i]) << (64 * i));
        exp_addr  = addr & ~32'h1F;
        exp_wr    = is_wr && !both;
        address_i = addr;
        line_i    = wline;
        read_i    = !is_wr || both;
        write_i   = is_wr || both;
        k = 0; since = 0; last_sent = 0; saw_resp = 0;
        for (int cyc = 0; cyc < 300 && !saw_resp; cyc++) begin
            @(negedge clk);
            n_cmp++;
            if (last_sent) begin
                if (resp_o !== 1'b1 || read_o !== 1'b0 || write_o !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s done: resp/rd/wr got %b%b%b want 100", tag, resp_o, read_o, write_o);
                end
                if (!exp_wr) begin
                    n_cmp++;
                    if (line_o !== exp_line) begin
                        n_bad++;
                        $display("FAIL %s line_o: got %h want %h", tag, line_o, exp_line);
                    end
                end
                saw_resp = 1;
                read_i   = 1'b0;
                write_i  = 1'b0;
                resp_i   = 1'b0;
            end else begin
                if (resp_o !== 1'b0 || read_o !== !exp_wr || write_o !== exp_wr) begin
                    n_bad++;
                    $display("FAIL %s busy cyc %0d: resp/rd/wr got %b%b%b want 0%b%b",
                             tag, cyc, resp_o, read_o, write_o, !exp_wr, exp_wr);
                end
                n_cmp++;
                if (address_o !== exp_addr) begin
                    n_bad++;
                    $display("FAIL %s address_o: got %h want %h", tag, address_o, exp_addr);
                end
                if (exp_wr) begin
                    n_cmp++;
                    if (burst_o !== wline[64*k +: 64]) begin
                        n_bad++;
                        $display("FAIL %s burst_o beat %0d: got %h want %h", tag, k, burst_o, wline[64*k +: 64]);
                    end
                end
                resp_i = 1'b0;
                if (since >= delay && gap[(since - delay) % 16]) begin
                    resp_i = 1'b1;
                    if (!exp_wr) burst_i = rd_beats[k];
                    k++;
                    if (k == 4) last_sent = 1;
                end
                since++;
            end
        end
        if (!saw_resp) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: resp_o not seen within 300 cycles", tag);
            read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (resp_o !== 1'b0 || read_o !== 1'b0 || write_o !== 1'b0 || address_o !== 32'h0) begin
            n_bad++;
            $display("FAIL %s idle after: resp/rd/wr got %b%b%b addr %h want 000 addr 0",
                     tag, resp_o, read_o, write_o, address_o);
        end
        $display("txn %-10s %s addr=%h delay=%0d gap=%h", tag, exp_wr ? "WR" : "RD", addr, delay, gap);
    endtask

    task automatic test_reset();
        n_cmp++;
        @(negedge clk);
        if ({resp_o, read_o, write_o} !== 3'b000 || address_o !== 0 || line_o !== 0 || burst_o !== 0) begin
            n_bad++;
            $display("FAIL reset_hold: outputs got r%b rd%b wr%b a%h nonzero want all 0", resp_o, read_o, write_o, address_o);
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({resp_o, read_o, write_o} !== 3'b000 || address_o !== 0 || burst_o !== 0) begin
            n_bad++;
            $display("FAIL reset_release: rd/wr/resp got %b%b%b want 000", read_o, write_o, resp_o);
        end
        // Mid-burst asynchronous reset: outputs must clear without a clock edge.
        address_i = 32'hCAFE_0040;
        line_i    = {rand64(), rand64(), rand64(), 64'hFFFF_0000_FFFF_0001};
        write_i   = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (write_o !== 1'b1 || burst_o !== 64'hFFFF_0000_FFFF_0001) begin
            n_bad++;
            $display("FAIL reset_pre: write_o %b burst_o %h want 1 ffff0000ffff0001", write_o, burst_o);
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({resp_o, read_o, write_o} !== 3'b000 || address_o !== 0 || line_o !== 0 || burst_o !== 0) begin
            n_bad++;
            $display("FAIL reset_async: got rd%b wr%b resp%b addr %h burst %h want all 0",
                     read_o, write_o, resp_o, address_o, burst_o);
        end
        write_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({resp_o, read_o, write_o} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_idle: rd/wr/resp got %b%b%b want 000", read_o, write_o, resp_o);
        end
        $display("txn reset      async assert/release checked");
    endtask

    task automatic test_read();
        run_txn("read", 1'b0, 1'b0, 32'h1234_567F, '0,
                {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                 64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 10, 16'hFFFF);
    endtask

    task automatic test_write();
        run_txn("write", 1'b1, 1'b0, 32'h0000_ABC4, {rand64(), rand64(), rand64(), rand64()},
                '0, 3, 16'hFFFF);
    endtask

    task automatic test_gapped();
        run_txn("gap_rd", 1'b0, 1'b0, $urandom, '0, {rand64(), rand64(), rand64(), rand64()}, 2, 16'h0059);
        run_txn("gap_wr", 1'b1, 1'b0, $urandom, {rand64(), rand64(), rand64(), rand64()}, '0, 1, 16'h0059);
    endtask

    task automatic test_reset_mid_read();
        address_i = 32'h0BAD_F00D;
        read_i    = 1'b1;
        @(negedge clk);
        resp_i  = 1'b1;
        burst_i = 64'hDEAD_DEAD_DEAD_DEAD;
        @(negedge clk);
        burst_i = 64'hBEEF_BEEF_BEEF_BEEF;
        @(negedge clk);
        resp_i = 1'b0;
        read_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (resp_o !== 1'b0 || read_o !== 1'b0 || line_o !== 256'h0) begin
            n_bad++;
            $display("FAIL midread_reset: resp %b read %b line %h want 0 0 0", resp_o, read_o, line_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn("post_rst", 1'b0, 1'b0, 32'h0BAD_F00D, '0, {rand64(), rand64(), rand64(), rand64()}, 1, 16'hFFFF);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_rd", 1'b0, 1'b0, $urandom, '0, {rand64(), rand64(), rand64(), rand64()}, 0, 16'hFFFF);
        run_txn("b2b_wr", 1'b1, 1'b0, $urandom, {rand64(), rand64(), rand64(), rand64()}, '0, 0, 16'hFFFF);
        run_txn("collide", 1'b0, 1'b1, $urandom, {rand64(), rand64(), rand64(), rand64()},
                {rand64(), rand64(), rand64(), rand64()}, 2, 16'hFFFF);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_txn("random", $urandom_range(1), 1'b0, $urandom,
                    {rand64(), rand64(), rand64(), rand64()},
                    {rand64(), rand64(), rand64(), rand64()},
                    $urandom_range(5), 16'($urandom) | 16'h0001);
        end
    endtask

    initial begin
        rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
        address_i = '0; line_i = '0; burst_i = '0;
        test_reset();
        test_read();
        test_write();
        test_gapped();
        test_reset_mid_read();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
